key_debounce_multi: RTL and testbench



---
 rtl/key_debounce_multi.sv | 126 ++++++++++++
 tb/tb_key_debounce_multi.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// N-channel push-button / slide-switch conditioner: synchroniser, mismatch-count
// debounce, press/release pulses and long-press detection per channel.
module key_debounce_multi #(
   parameter int N          = 4,
   parameter int DELAY      = 1000000,
   parameter int LONG       = 50000000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic         iCLK,
   input  logic         iRST_N,
   input  logic [N-1:0] iKEY,
   output logic [N-1:0] oPRESSED,
   output logic [N-1:0] oPRESS_P,
   output logic [N-1:0] oRELEASE_P,
   output logic [N-1:0] oLONG_P,
   output logic [N-1:0] oHELD,
   output logic         oANY_P
);

   localparam int DW = $clog2(DELAY + 1);
   localparam int HW = (LONG > 0) ? $clog2(LONG + 1) : 1;
   localparam logic [DW-1:0] D_LAST = DW'(DELAY - 1);
   localparam logic [HW-1:0] H_LAST = HW'(LONG);
   // Pin level that means "not pressed"; synchronisers reset to it so reset
   // release with idle pins never looks like an edge.
   localparam logic IDLE = (ACTIVE_LOW != 0);

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_ch
         logic          sync1_q;
         logic          sync2_q;
         logic          lv;
         logic          st_q,    st_d;
         logic [DW-1:0] dcnt_q,  dcnt_d;
         logic          press_q, press_d;
         logic          rel_q,   rel_d;

         assign lv = sync2_q ^ IDLE;

         // Any cycle where the level agrees with the state restarts the count.
         always_comb begin
            st_d    = st_q;
            dcnt_d  = '0;
            press_d = 1'b0;
            rel_d   = 1'b0;
            if (lv != st_q) begin
               if (dcnt_q == D_LAST) begin
                  st_d    = lv;
                  press_d = lv;
                  rel_d   = ~lv;
               end else begin
                  dcnt_d = dcnt_q + DW'(1);
               end
            end
         end

         always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N) begin
               sync1_q <= IDLE;
               sync2_q <= IDLE;
               st_q    <= 1'b0;
               dcnt_q  <= '0;
               press_q <= 1'b0;
               rel_q   <= 1'b0;
            end else begin
               sync1_q <= iKEY[g];
               sync2_q <= sync1_q;
               st_q    <= st_d;
               dcnt_q  <= dcnt_d;
               press_q <= press_d;
               rel_q   <= rel_d;
            end
         end

         assign oPRESSED[g]   = st_q;
         assign oPRESS_P[g]   = press_q;
         assign oRELEASE_P[g] = rel_q;

         if (LONG > 0) begin : g_long
            logic [HW-1:0] hcnt_q, hcnt_d;
            logic          long_q, long_d;
            logic          held_q, held_d;

            // Counting starts the cycle after the press edge; looking at st_d
            // lets oHELD drop together with the release pulse.
            always_comb begin
               hcnt_d = hcnt_q;
               long_d = 1'b0;
               held_d = held_q;
               if (!st_q || !st_d) begin
                  hcnt_d = '0;
                  held_d = 1'b0;
               end else if (hcnt_q < H_LAST) begin
                  hcnt_d = hcnt_q + HW'(1);
                  if (hcnt_d == H_LAST) begin
                     long_d = 1'b1;
                     held_d = 1'b1;
                  end
               end
            end

            always_ff @(posedge iCLK or negedge iRST_N) begin
               if (!iRST_N) begin
                  hcnt_q <= '0;
                  long_q <= 1'b0;
                  held_q <= 1'b0;
               end else begin
                  hcnt_q <= hcnt_d;
                  long_q <= long_d;
                  held_q <= held_d;
               end
            end

            assign oLONG_P[g] = long_q;
            assign oHELD[g]   = held_q;
         end else begin : g_no_long
            assign oLONG_P[g] = 1'b0;
            assign oHELD[g]   = 1'b0;
         end
      end
   endgenerate

   assign oANY_P = |oPRESS_P;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: two DELAY=4 instances (LONG=10 and LONG=0)
// sharing pins, plus a DELAY=1 active-high instance.
module tb_key_debounce_multi;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] key_a = 2'b11;
   logic [0:0] key_c = 1'b0;

   logic [1:0] a_pressed, a_press, a_rel, a_long, a_held;
   logic       a_any;
   logic [1:0] b_pressed, b_press, b_rel, b_long, b_held;
   logic       b_any;
   logic [0:0] c_pressed, c_press, c_rel, c_long, c_held;
   logic       c_any;

   always #5 clk = ~clk;

   key_debounce_multi #(.N(2), .DELAY(4), .LONG(10), .ACTIVE_LOW(1)) u_a (
      .iCLK(clk), .iRST_N(rst_n), .iKEY(key_a),
      .oPRESSED(a_pressed), .oPRESS_P(a_press), .oRELEASE_P(a_rel),
      .oLONG_P(a_long), .oHELD(a_held), .oANY_P(a_any)
   );

   key_debounce_multi #(.N(2), .DELAY(4), .LONG(0), .ACTIVE_LOW(1)) u_b (
      .iCLK(clk), .iRST_N(rst_n), .iKEY(key_a),
      .oPRESSED(b_pressed), .oPRESS_P(b_press), .oRELEASE_P(b_rel),
      .oLONG_P(b_long), .oHELD(b_held), .oANY_P(b_any)
   );

   key_debounce_multi #(.N(1), .DELAY(1), .LONG(2), .ACTIVE_LOW(0)) u_c (
      .iCLK(clk), .iRST_N(rst_n), .iKEY(key_c),
      .oPRESSED(c_pressed), .oPRESS_P(c_press), .oRELEASE_P(c_rel),
      .oLONG_P(c_long), .oHELD(c_held), .oANY_P(c_any)
   );

   typedef struct packed {
      logic [1:0] pressed;
      logic [1:0] press;
      logic [1:0] rel;
      logic [1:0] lng;
      logic [1:0] held;
      logic       any;
   } obs_t;

   typedef struct {
      logic [1:0] key;
      int         n;
      obs_t       exp;
   } vec_t;

   vec_t tbl[$];
   int   tests = 0;
   int   fails = 0;

   function automatic obs_t mk(input logic [1:0] p, input logic [1:0] pp, input logic [1:0] rp,
                               input logic [1:0] lp, input logic [1:0] hd, input logic an);
      obs_t o;
      o.pressed = p; o.press = pp; o.rel = rp; o.lng = lp; o.held = hd; o.any = an;
      return o;
   endfunction

   task automatic add(input logic [1:0] key, input int n, input obs_t exp);
      vec_t v;
      v.key = key; v.n = n; v.exp = exp;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input int cyc, input logic [10:0] act, input logic [10:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc %0d: got %b, expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic check_ab(input string name, input int cyc, input obs_t exp);
      obs_t exp_b;
      exp_b = exp;
      exp_b.lng = 2'b00;
      exp_b.held = 2'b00;
      check({name, "_a"}, cyc, {a_pressed, a_press, a_rel, a_long, a_held, a_any}, exp);
      check({name, "_b"}, cyc, {b_pressed, b_press, b_rel, b_long, b_held, b_any}, exp_b);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Events only land on the final cycle of each record; earlier cycles must be pulse-free.
   task automatic apply(input string name, input logic [1:0] key, input int n, input obs_t exp);
      obs_t mid;
      mid = exp;
      mid.press = 2'b00; mid.rel = 2'b00; mid.lng = 2'b00; mid.any = 1'b0;
      key_a = key;
      for (int i = 0; i < n; i++) begin
         step();
         if (i < n - 1) check_ab(name, i, mid);
         else           check_ab(name, i, exp);
      end
   endtask

   // C expectation bits: {pressed, press, rel, long, held}
   task automatic apply_c(input string name, input logic key, input int n, input logic [4:0] exp);
      logic [4:0] mid;
      mid = exp & 5'b10001;
      key_c = key;
      for (int i = 0; i < n; i++) begin
         step();
         check(name, i, {6'd0, c_pressed, c_press, c_rel, c_long, c_held},
               {6'd0, (i < n - 1) ? mid : exp});
         check({name, "_any"}, i, {10'd0, c_any}, {10'd0, (i < n - 1) ? 1'b0 : exp[3]});
      end
   endtask

   initial begin
      // idle / single press / release on channel 0
      add(2'b11, 8,  mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      add(2'b10, 5,  mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      add(2'b10, 1,  mk(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1));
      add(2'b10, 1,  mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      add(2'b11, 5,  mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      add(2'b11, 1,  mk(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0));
      add(2'b11, 1,  mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      // bounce 3 low / 1 high / 3 low, then a solid press held into long-press
      add(2'b10, 3,  mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      add(2'b11, 1,  mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      add(2'b10, 3,  mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      add(2'b11, 4,  mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      add(2'b10, 5,  mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      add(2'b10, 1,  mk(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1));
      add(2'b10, 9,  mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      add(2'b10, 1,  mk(2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0));
      add(2'b10, 1,  mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0));
      add(2'b10, 20, mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0));
      add(2'b11, 5,  mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0));
      add(2'b11, 1,  mk(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0));
      add(2'b11, 1,  mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      // both channels pressed and released on the same edge
      add(2'b00, 5,  mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      add(2'b00, 1,  mk(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1));
      add(2'b00, 1,  mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      add(2'b11, 5,  mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      add(2'b11, 1,  mk(2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0));
      add(2'b11, 1,  mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));

      // reset phase
      rst_n = 1'b0;
      key_a = 2'b11;
      key_c = 1'b0;
      repeat (3) begin
         step();
         check_ab("in_reset", 0, '0);
         check("in_reset_c", 0, {5'd0, c_pressed, c_press, c_rel, c_long, c_held, c_any}, '0);
      end
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++)
         apply($sformatf("vec%0d", i), tbl[i].key, tbl[i].n, tbl[i].exp);

      // key 1 held, reset mid long-count, key still held across reset release
      apply("k1_dly",  2'b01, 5, mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      apply("k1_prs",  2'b01, 1, mk(2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1));
      apply("k1_hold", 2'b01, 5, mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      #2;
      rst_n = 1'b0;
      #1;
      check_ab("async_rst", 0, '0);
      step();
      check_ab("rst_hold", 0, '0);
      step();
      check_ab("rst_hold", 1, '0);
      rst_n = 1'b1;
      apply("re_dly",  2'b01, 5, mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      apply("re_prs",  2'b01, 1, mk(2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1));
      apply("re_cnt",  2'b01, 9, mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
      apply("re_long", 2'b01, 1, mk(2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0));
      apply("re_held", 2'b01, 1, mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0));
      apply("re_rdly", 2'b11, 5, mk(2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0));
      apply("re_rel",  2'b11, 1, mk(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0));
      apply("re_idle", 2'b11, 1, mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));

      // DELAY=1, active-high, LONG=2
      apply_c("c_dly",   1'b1, 2, 5'b00000);
      apply_c("c_prs",   1'b1, 1, 5'b11000);
      apply_c("c_cnt",   1'b1, 1, 5'b10000);
      apply_c("c_long",  1'b1, 1, 5'b10011);
      apply_c("c_held",  1'b1, 1, 5'b10001);
      apply_c("c_rdly",  1'b0, 2, 5'b10001);
      apply_c("c_rel",   1'b0, 1, 5'b00100);
      apply_c("c_idle",  1'b0, 1, 5'b00000);
      // one-cycle glitch is accepted at DELAY=1 and still gives single pulses
      apply_c("c_g_hi",  1'b1, 1, 5'b00000);
      apply_c("c_g_lo",  1'b0, 1, 5'b00000);
      apply_c("c_g_prs", 1'b0, 1, 5'b11000);
      apply_c("c_g_rel", 1'b0, 1, 5'b00100);
      apply_c("c_g_end", 1'b0, 2, 5'b00000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
